// File: rtl/bcd_timer_ctrl.sv
// 4-digit BCD up-counter with prescaler and IDLE/RUN/PAUSE/DONE control.
// Commands are level-sensitive with priority Clear > Stop > Start.
// When target compare is enabled, reaching the target count stops the counter in DONE.
module bcd_timer_ctrl #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stop,
  input  logic        Clear,
  input  logic        TargetEn,
  input  logic [15:0] Target,
  output logic [15:0] Count,
  output logic [1:0]  State,
  output logic        Running,
  output logic        Done,
  output logic        Wrap
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  localparam logic [15:0] PresLast = 16'(PRESCALE - 1);

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] presc_q;
  logic        wrap_q;

  logic [15:0] count_inc;
  logic        count_wrap;
  logic        target_valid;
  logic        target_hit;
  logic        presc_last;

  // Ripple-carry BCD increment of the current count, plus target decode.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    count_inc    = '0;
    carry        = 1'b1;
    target_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      digit = count_q[4*i +: 4];
      if (carry && digit == 4'd9) begin
        count_inc[4*i +: 4] = 4'd0;
      end else if (carry) begin
        count_inc[4*i +: 4] = digit + 4'd1;
        carry               = 1'b0;
      end else begin
        count_inc[4*i +: 4] = digit;
      end
      if (Target[4*i +: 4] > 4'd9) begin
        target_valid = 1'b0;
      end
    end
    count_wrap = carry;
    // A target with a non-BCD digit can never equal a BCD count.
    target_hit = target_valid && (count_inc == Target);
    presc_last = (presc_q == PresLast);
  end

  // Control FSM, prescaler, count and wrap pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      count_q <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (Clear) begin
        state_q <= StIdle;
        count_q <= '0;
        presc_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (!Stop && Start) begin
              state_q <= StRun;
              presc_q <= '0;
            end
          end
          StRun: begin
            if (Stop) begin
              // Prescaler and count hold; any tick due this cycle is dropped.
              state_q <= StPause;
            end else if (presc_last) begin
              presc_q <= '0;
              count_q <= count_inc;
              wrap_q  <= count_wrap;
              if (TargetEn && target_hit) begin
                state_q <= StDone;
              end
            end else begin
              presc_q <= presc_q + 16'd1;
            end
          end
          StPause: begin
            if (!Stop && Start) begin
              state_q <= StRun;
            end
          end
          StDone: begin
            state_q <= StDone;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign Count   = count_q;
  assign State   = state_q;
  assign Running = (state_q == StRun);
  assign Done    = (state_q == StDone);
  assign Wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: one instance with PRESCALE=4 and one with PRESCALE=1
// share stimulus; expectations go through a scoreboard queue.
module tb_bcd_timer_ctrl;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Stop;
  logic        Clear;
  logic        TargetEn;
  logic [15:0] Target;

  logic [15:0] count4, count1;
  logic [1:0]  state4, state1;
  logic        running4, running1;
  logic        done4, done1;
  logic        wrap4, wrap1;

  typedef struct {
    logic [1:0]  state;
    logic [15:0] count;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  bcd_timer_ctrl #(.PRESCALE(4)) u_dut4 (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Stop     (Stop),
    .Clear    (Clear),
    .TargetEn (TargetEn),
    .Target   (Target),
    .Count    (count4),
    .State    (state4),
    .Running  (running4),
    .Done     (done4),
    .Wrap     (wrap4)
  );

  bcd_timer_ctrl #(.PRESCALE(1)) u_dut1 (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Stop     (Stop),
    .Clear    (Clear),
    .TargetEn (TargetEn),
    .Target   (Target),
    .Count    (count1),
    .State    (state1),
    .Running  (running1),
    .Done     (done1),
    .Wrap     (wrap1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge, leave 1 time unit for outputs to settle.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic exp_t mk(input logic [1:0] s, input logic [15:0] c, input logic w);
    exp_t e;
    e.state = s;
    e.count = c;
    e.wrap  = w;
    return e;
  endfunction

  task automatic do_clear();
    Start = 1'b0;
    Stop  = 1'b0;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({count4, state4, running4, done4, wrap4} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_p4 got count=%h state=%b run=%b done=%b wrap=%b want all zero",
               count4, state4, running4, done4, wrap4);
    end
    n_tests++;
    if ({count1, state1, running1, done1, wrap1} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_p1 got count=%h state=%b run=%b done=%b wrap=%b want all zero",
               count1, state1, running1, done1, wrap1);
    end
  endtask

  // Start pulse at edge 0: RUN from edge 0, 0001 after edge 4, 0002 after edge 8.
  task automatic test_latency();
    exp_t e;
    do_clear();
    TargetEn = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      sb.push_back(mk(2'b01, (k >= 8) ? 16'h0002 : (k >= 4) ? 16'h0001 : 16'h0000, 1'b0));
    end
    Start = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      Start = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if (state4 !== e.state || count4 !== e.count || running4 !== 1'b1) begin
        n_fail++;
        $display("FAIL latency edge %0d got state=%b count=%h run=%b want state=%b count=%h run=1",
                 k, state4, count4, running4, e.state, e.count);
      end
    end
  endtask

  // PRESCALE=1 counts every edge; covers 0009->0010, 0999->1000 and 9999->0000 with Wrap.
  task automatic test_carry_wrap();
    exp_t e;
    do_clear();
    TargetEn = 1'b0;
    Start    = 1'b1;
    for (int n = 0; n <= 10001; n++) begin
      sb.push_back(mk(2'b01, to_bcd(n % 10000), n == 10000));
      tick();
      e = sb.pop_front();
      n_tests++;
      if (state1 !== e.state || count1 !== e.count || wrap1 !== e.wrap) begin
        n_fail++;
        $display("FAIL carry_wrap edge %0d got state=%b count=%h wrap=%b want state=%b count=%h wrap=%b",
                 n, state1, count1, wrap1, e.state, e.count, e.wrap);
      end
    end
    Start = 1'b0;
  endtask

  // Target 0003 with PRESCALE=1: stops in DONE, ignores Start, leaves only on Clear.
  task automatic test_target();
    exp_t e;
    do_clear();
    TargetEn = 1'b1;
    Target   = 16'h0003;
    sb.push_back(mk(2'b01, 16'h0000, 1'b0));
    sb.push_back(mk(2'b01, 16'h0001, 1'b0));
    sb.push_back(mk(2'b01, 16'h0002, 1'b0));
    sb.push_back(mk(2'b11, 16'h0003, 1'b0));
    sb.push_back(mk(2'b11, 16'h0003, 1'b0));
    sb.push_back(mk(2'b11, 16'h0003, 1'b0));
    Start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        Start = 1'b0;
        Stop  = 1'b1;
      end
      tick();
      e = sb.pop_front();
      n_tests++;
      if (state1 !== e.state || count1 !== e.count || done1 !== (e.state == 2'b11)) begin
        n_fail++;
        $display("FAIL target edge %0d got state=%b count=%h done=%b want state=%b count=%h",
                 k, state1, count1, done1, e.state, e.count);
      end
    end
    Stop = 1'b0;
    do_clear();
    n_tests++;
    if (state1 !== 2'b00 || count1 !== 16'h0000 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL target_clear got state=%b count=%h done=%b want state=00 count=0000 done=0",
               state1, count1, done1);
    end
  endtask

  // A non-BCD target never matches; a target equal to the count without a tick does nothing.
  task automatic test_target_nomatch();
    do_clear();
    TargetEn = 1'b1;
    Target   = 16'h000A;
    Start    = 1'b1;
    for (int k = 0; k < 13; k++) tick();
    Start = 1'b0;
    n_tests++;
    if (state1 !== 2'b01 || count1 !== 16'h0012) begin
      n_fail++;
      $display("FAIL target_invalid got state=%b count=%h want state=01 count=0012",
               state1, count1);
    end
    do_clear();
    Target = 16'h0000;
    Start  = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    Start = 1'b0;
    n_tests++;
    if (state4 !== 2'b01 || count4 !== 16'h0000) begin
      n_fail++;
      $display("FAIL target_no_tick got state=%b count=%h want state=01 count=0000",
               state4, count4);
    end
    TargetEn = 1'b0;
  endtask

  // Stop on the tick edge holds prescaler at 3; Stop+Start stays paused; Start ticks next edge.
  task automatic test_stop_on_tick();
    exp_t e;
    do_clear();
    TargetEn = 1'b0;
    Start    = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    sb.push_back(mk(2'b10, 16'h0000, 1'b0));
    sb.push_back(mk(2'b10, 16'h0000, 1'b0));
    sb.push_back(mk(2'b10, 16'h0000, 1'b0));
    sb.push_back(mk(2'b01, 16'h0000, 1'b0));
    sb.push_back(mk(2'b01, 16'h0001, 1'b0));
    for (int k = 0; k < 5; k++) begin
      Stop  = (k < 3);
      Start = (k == 2) || (k == 3);
      tick();
      e = sb.pop_front();
      n_tests++;
      if (state4 !== e.state || count4 !== e.count) begin
        n_fail++;
        $display("FAIL stop_tick step %0d got state=%b count=%h want state=%b count=%h",
                 k, state4, count4, e.state, e.count);
      end
    end
    Start = 1'b0;
    Stop  = 1'b0;
  endtask

  // Clear, Stop and Start together in RUN: Clear wins.
  task automatic test_clear_all();
    do_clear();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    n_tests++;
    if (count4 !== 16'h0001) begin
      n_fail++;
      $display("FAIL clear_all_pre got count=%h want 0001", count4);
    end
    Clear = 1'b1;
    Stop  = 1'b1;
    Start = 1'b1;
    tick();
    Clear = 1'b0;
    Stop  = 1'b0;
    Start = 1'b0;
    n_tests++;
    if (state4 !== 2'b00 || count4 !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_all got state=%b count=%h want state=00 count=0000", state4, count4);
    end
  endtask

  // Asynchronous reset between edges at count 0427, then wait in IDLE for Start.
  task automatic test_async_reset();
    do_clear();
    Start = 1'b1;
    for (int n = 0; n <= 427; n++) tick();
    n_tests++;
    if (count1 !== 16'h0427) begin
      n_fail++;
      $display("FAIL async_pre got count=%h want 0427", count1);
    end
    #2;
    Reset = 1'b1;
    #1;
    n_tests++;
    if ({count1, state1, running1, done1, wrap1} !== 21'd0) begin
      n_fail++;
      $display("FAIL async_reset got count=%h state=%b run=%b done=%b wrap=%b want all zero",
               count1, state1, running1, done1, wrap1);
    end
    Start = 1'b0;
    #2;
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n_tests++;
    if (state1 !== 2'b00 || count1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_idle got state=%b count=%h want state=00 count=0000", state1, count1);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n_tests++;
    if (running1 !== 1'b1 || count1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_restart got run=%b count=%h want run=1 count=0000", running1, count1);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    Start    = 1'b0;
    Stop     = 1'b0;
    Clear    = 1'b0;
    TargetEn = 1'b0;
    Target   = 16'h0000;
    #12;
    test_reset();
    Reset = 1'b0;
    tick();
    test_latency();
    test_carry_wrap();
    test_target();
    test_target_nomatch();
    test_stop_on_tick();
    test_clear_all();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4, giving Clk cycles per count tick; legal range 1..65535.
REQ-002 The block SHALL have port Clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port Start, input, 1, level command to begin or resume counting.
REQ-005 The block SHALL have port Stop, input, 1, level command to pause counting.
REQ-006 The block SHALL have port Clear, input, 1, level command to zero the count and return to IDLE.
REQ-007 The block SHALL have port TargetEn, input, 1, which enables target compare.
REQ-008 The block SHALL have port Target, input, 16, holding 4 BCD digits ([3:0] = units).
REQ-009 The block SHALL have port Count, output, 16, holding 4 BCD digits of the current count ([3:0] = units).
REQ-010 The block SHALL have port State, output, 2, encoded IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-011 The block SHALL have port Running, output, 1, equal to 1 iff State==RUN.
REQ-012 The block SHALL have port Done, output, 1, equal to 1 iff State==DONE.
REQ-013 The block SHALL have port Wrap, output, 1, a one-cycle pulse when Count rolls over from 9999 to 0000.

Function
REQ-014 All state SHALL be registered on the Clk rising edge, and all outputs SHALL be registered or decoded directly from registers, with no combinational input-to-output path.
REQ-015 Command priority SHALL be Clear > Stop > Start, evaluated each cycle.
REQ-016 Clear in any state SHALL set State=IDLE, Count=0000 and prescaler=0 on the next edge.
REQ-017 From IDLE, Start SHALL enter RUN with prescaler=0; Stop SHALL be ignored.
REQ-018 From RUN, Stop SHALL enter PAUSE, holding Count and the prescaler value.
REQ-019 From PAUSE, Start SHALL re-enter RUN and resume from the held prescaler value.
REQ-020 In DONE, Start and Stop SHALL be ignored; only Clear or Reset SHALL leave DONE.
REQ-021 The prescaler SHALL advance only in RUN cycles with Clear=0 and Stop=0: if it equals PRESCALE-1, it SHALL reload to 0 and issue a tick; otherwise it SHALL increment.
REQ-022 On a tick, the units digit SHALL increment; any digit at 9 with an incoming carry SHALL become 0 and carry into the next digit.
REQ-023 A tick at 9999 SHALL produce 0000, with Wrap=1 in the cycle following that edge only.
REQ-024 On a tick with TargetEn=1 whose next Count equals Target, the block SHALL update Count and enter DONE on the same edge.
REQ-025 A Target containing any digit >9 SHALL never match.
REQ-026 Target compare SHALL occur only on ticks, so a Target equal to the current Count without a tick SHALL not enter DONE.
REQ-027 A Clear or Stop cycle SHALL suppress any tick due in that cycle.
REQ-028 With PRESCALE=1, a tick SHALL occur every RUN cycle.
REQ-029 Start held continuously SHALL be harmless, and a State transition SHALL take one edge from the command cycle.
REQ-030 Latency: with Start sampled on edge k from IDLE, Running SHALL be 1 after edge k and the first tick SHALL occur on edge k+PRESCALE.

Reset
REQ-031 Reset SHALL force, asynchronously, State=IDLE, Count=0000, prescaler=0, Running=0, Done=0 and Wrap=0.
REQ-032 Reset asserted mid-RUN or mid-DONE SHALL discard all progress, and after release the block SHALL wait in IDLE for Start.
REQ-033 Deassertion of Reset SHALL be synchronous-safe: the first active edge after release SHALL evaluate commands normally.

Verification
REQ-034 PRESCALE=4, Start pulse at edge 0 -> Running=1 from edge 0; Count=0001 after edge 4, Count=0002 after edge 8.
REQ-035 Count=0009, tick -> 0010; Count=0999, tick -> 1000; Count=9999, tick -> 0000 with Wrap high for exactly one cycle.
REQ-036 TargetEn=1, Target=0003, PRESCALE=1, Start -> Count 0001, 0002, 0003; State=DONE and Done=1 with Count=0003; a later Start leaves the block in DONE; Clear -> IDLE with Count=0000.
REQ-037 PRESCALE=4, Stop asserted on a tick cycle -> PAUSE with no increment and the prescaler held at 3; Start -> tick on the next RUN edge.
REQ-038 Clear, Stop and Start asserted together in RUN -> IDLE with Count=0000; Stop and Start together in PAUSE -> remains in PAUSE.
REQ-039 Reset pulsed asynchronously between edges during RUN at Count=0427 -> outputs go to reset values immediately, and Count stays 0000 until a new Start.
